// File: rtl/strobe_fifo.sv
// rtl/strobe_fifo.sv - single-clock FIFO with optional rising-edge strobe synchronisers
module strobe_fifo #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 200,
  parameter int EDGE_MODE = 1,
  parameter int AF_THRESH = DEPTH - 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            w_data,
  input  logic                         w_en,
  input  logic                         r_en,
  input  logic                         clr_err,
  output logic [DATA_W-1:0]            r_data,
  output logic                         r_valid,
  output logic                         d_available,
  output logic                         full,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic w_req, r_req;

  // Strobes are level signals from another domain: synchronise, then detect the rising edge.
  if (EDGE_MODE == 1) begin : g_edge
    logic w_s1_q, w_s2_q, w_h_q;
    logic r_s1_q, r_s2_q, r_h_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_s1_q <= 1'b0;
        w_s2_q <= 1'b0;
        w_h_q  <= 1'b0;
        r_s1_q <= 1'b0;
        r_s2_q <= 1'b0;
        r_h_q  <= 1'b0;
      end else begin
        w_s1_q <= w_en;
        w_s2_q <= w_s1_q;
        w_h_q  <= w_s2_q;
        r_s1_q <= r_en;
        r_s2_q <= r_s1_q;
        r_h_q  <= r_s2_q;
      end
    end

    assign w_req = w_s2_q & ~w_h_q;
    assign r_req = r_s2_q & ~r_h_q;
  end else begin : g_level
    assign w_req = w_en;
    assign r_req = r_en;
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;
  logic              avail_q, avail_d;
  logic              full_q, full_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_do, wr_do;

  always_comb begin
    rd_do    = r_req && (level_q != '0);
    // A read at the same edge frees the slot, so a write into a full FIFO still proceeds.
    wr_do    = w_req && ((level_q != LVL_FULL) || rd_do);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    r_data_d = r_data_q;
    r_valid_d = rd_do;

    if (wr_do) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_do) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      r_data_d = mem[rd_ptr_q];
    end
    if (wr_do && !rd_do) begin
      level_d = level_q + 1'b1;
    end else if (rd_do && !wr_do) begin
      level_d = level_q - 1'b1;
    end

    avail_d = (level_d != '0);
    full_d  = (level_d == LVL_FULL);
    af_d    = (level_d >= LVL_AF);

    // A fresh error event at the clearing edge takes priority over the clear.
    ovf_d = (ovf_q & ~clr_err) | (w_req & ~wr_do);
    unf_d = (unf_q & ~clr_err) | (r_req & (level_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      avail_q   <= 1'b0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      avail_q   <= avail_d;
      full_q    <= full_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[wr_ptr_q] <= w_data;
    end
  end

  assign r_data      = r_data_q;
  assign r_valid     = r_valid_q;
  assign d_available = avail_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
